iddmm_res_buf: RTL and testbench
================================

IDDMM_RES_BUF -- requirements
Module: iddmm_res_buf

Interface
REQ-001 SHALL have parameter K, default 128, meaning result word width in bits.
REQ-002 SHALL have parameter N, default 32, meaning words per result, legal range N >= 2.
REQ-003 SHALL have parameter ADDR_W, default $clog2(N), meaning word index width.
REQ-004 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port task_grant  input  1  result word valid from the Montgomery controller.
REQ-007 SHALL have port task_end  input  1  high together with the final task_grant word of a result.
REQ-008 SHALL have port task_res  input  K  result word, LSW first, one per task_grant cycle.
REQ-009 SHALL have port res_valid  output  1  drain word valid.
REQ-010 SHALL have port res_ready  input  1  consumer accepts word when res_valid && res_ready.
REQ-011 SHALL have port res_data  output  K  drain word.
REQ-012 SHALL have port res_idx  output  ADDR_W  word index of res_data.
REQ-013 SHALL have port res_last  output  1  marks final drain word.
REQ-014 SHALL have port busy  output  1  high in CAPTURE or DRAIN.
REQ-015 SHALL have port len_err  output  1  sticky: word count of a result != N.
REQ-016 SHALL have port ovf_err  output  1  sticky: task_grant seen during DRAIN.
REQ-017 SHALL have port err_clr  input  1  synchronous clear of len_err and ovf_err.

Function
REQ-018 SHALL implement FSM states IDLE, CAPTURE, DRAIN; IDLE -> CAPTURE on task_grant && !task_end; IDLE -> DRAIN on task_grant && task_end.
REQ-019 SHALL write task_res into internal N x K buffer at wr_cnt on every task_grant cycle in IDLE/CAPTURE, then wr_cnt+1; wr_cnt reset to 0 on entering IDLE.
REQ-020 SHALL go CAPTURE -> DRAIN on the cycle after task_end is sampled with task_grant.
REQ-021 SHALL, when wr_cnt reaches N without task_end, drop further words, set len_err, and stay in CAPTURE until task_end.
REQ-022 SHALL, when task_end arrives with wr_cnt+1 != N, set len_err and drain exactly N words (unwritten entries hold stale data).
REQ-023 SHALL assert res_valid the cycle after task_end is sampled, holding the first drain word, forwarded from task_res if that word is being written that same cycle.
REQ-024 SHALL hold res_data, res_idx, res_last stable while res_valid && !res_ready.
REQ-025 SHALL present the next word the cycle after each handshake, sustaining 1 word/cycle with res_ready held high.
REQ-026 SHALL assert res_last only with the N-th drain word; after its handshake, DRAIN -> IDLE and res_valid drops next cycle.
REQ-027 SHALL ignore task_grant/task_res during DRAIN and set ovf_err; buffer contents unaffected.
REQ-028 SHALL give err_clr priority over a same-cycle error set (clear wins).
REQ-029 SHALL keep busy high from the first captured word through the final handshake.

Reset
REQ-030 SHALL on rst_n low asynchronously force IDLE, wr_cnt=0, rd_cnt=0, res_valid=0, res_data=0, res_idx=0, res_last=0, busy=0, len_err=0, ovf_err=0.
REQ-031 SHALL abandon any partial capture or drain on reset; buffer contents need not be cleared.

Configuration
REQ-032 SHALL, with macro IDDMM_RES_MSW_FIRST_EN defined, drain in index order N-1 down to 0, res_last on index 0; without it, drain 0 up to N-1, res_last on index N-1; res_idx always reports the true buffer index.

Verification
REQ-033 SHALL pass: N=32, words 0..31 = value i, res_ready=1 -> res_valid one cycle after task_end, 32 consecutive words 0..31, res_last on idx 31, busy low afterwards.
REQ-034 SHALL pass: res_ready toggled 1/0 each cycle -> each word held across stalls, no loss/duplication, 32 handshakes total.
REQ-035 SHALL pass: task_end on 20th word -> len_err=1, 32 words drained; err_clr pulse -> len_err=0.
REQ-036 SHALL pass: 40 task_grant words, task_end on 40th -> words 0..31 drained unchanged, len_err=1.
REQ-037 SHALL pass: task_grant burst while draining with res_ready=0 -> ovf_err=1, drained data equals first result.
REQ-038 SHALL pass: rst_n low mid-drain at word 10 -> all outputs at reset values; next full result drains correctly from word 0 (or word 31 with IDDMM_RES_MSW_FIRST_EN, first word forwarded same cycle).

Source files
------------

// File: rtl/iddmm_res_buf.sv
// Captures one Montgomery result (N words of K bits, LSW first) and drains it over a valid/ready port.
// Drain order is 0..N-1 by default; defining IDDMM_RES_MSW_FIRST_EN drains N-1..0 instead.
module iddmm_res_buf #(
  parameter int K      = 128,
  parameter int N      = 32,
  parameter int ADDR_W = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              task_grant,
  input  logic              task_end,
  input  logic [K-1:0]      task_res,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [K-1:0]      res_data,
  output logic [ADDR_W-1:0] res_idx,
  output logic              res_last,
  output logic              busy,
  output logic              len_err,
  output logic              ovf_err,
  input  logic              err_clr
);

  typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_t;

  localparam logic [ADDR_W:0]   N_CNT   = (ADDR_W+1)'(N);
  localparam logic [ADDR_W:0]   WR_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] RD_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] LAST_M1 = ADDR_W'(N-2);

  state_t            state, state_nxt;
  logic [K-1:0]      mem [N];
  logic [ADDR_W:0]   wr_cnt;
  logic [ADDR_W-1:0] rd_cnt;

  logic              accepting, wr_en, end_hit, hs, drain_done, len_set, ovf_set;
  logic [ADDR_W-1:0] first_idx, next_idx;
  logic [K-1:0]      first_word;

  // Maps the drain sequence number onto the true buffer index.
  function automatic logic [ADDR_W-1:0] drain_idx(input logic [ADDR_W-1:0] cnt);
`ifdef IDDMM_RES_MSW_FIRST_EN
    return ADDR_W'(N-1) - cnt;
`else
    return cnt;
`endif
  endfunction

  assign accepting  = (state != DRAIN);
  assign wr_en      = task_grant && accepting && (wr_cnt != N_CNT);
  assign end_hit    = task_grant && task_end && accepting;
  assign hs         = res_valid && res_ready;
  assign drain_done = (state == DRAIN) && hs && res_last;
  assign len_set    = (task_grant && accepting && (wr_cnt == N_CNT)) ||
                      (end_hit && ((wr_cnt + WR_ONE) != N_CNT));
  assign ovf_set    = task_grant && (state == DRAIN);
  assign busy       = (state != IDLE);

  assign first_idx  = drain_idx('0);
  assign next_idx   = drain_idx(rd_cnt + RD_ONE);
  // The first drain word may be the one landing in the buffer this very cycle.
  assign first_word = (wr_en && (wr_cnt[ADDR_W-1:0] == first_idx)) ? task_res : mem[first_idx];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (task_grant) state_nxt = task_end ? DRAIN : CAPTURE;
      CAPTURE: if (task_grant && task_end) state_nxt = DRAIN;
      DRAIN:   if (hs && res_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_cnt[ADDR_W-1:0]] <= task_res;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt    <= '0;
      rd_cnt    <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_idx   <= '0;
      res_last  <= 1'b0;
    end else begin
      if (drain_done)  wr_cnt <= '0;
      else if (wr_en)  wr_cnt <= wr_cnt + WR_ONE;

      if (end_hit) begin
        res_valid <= 1'b1;
        res_data  <= first_word;
        res_idx   <= first_idx;
        res_last  <= 1'b0;
        rd_cnt    <= '0;
      end else if ((state == DRAIN) && hs) begin
        if (res_last) begin
          res_valid <= 1'b0;
          res_last  <= 1'b0;
          rd_cnt    <= '0;
        end else begin
          rd_cnt   <= rd_cnt + RD_ONE;
          res_data <= mem[next_idx];
          res_idx  <= next_idx;
          res_last <= (rd_cnt == LAST_M1);
        end
      end
    end
  end

  // Clear beats a same-cycle set on both sticky flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_err <= 1'b0;
      ovf_err <= 1'b0;
    end else if (err_clr) begin
      len_err <= 1'b0;
      ovf_err <= 1'b0;
    end else begin
      if (len_set) len_err <= 1'b1;
      if (ovf_set) ovf_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_iddmm_res_buf.sv
// Randomized scoreboard bench for iddmm_res_buf: expected drain words are queued at issue time and
// popped by an independent monitor on every handshake.
module tb_iddmm_res_buf;

  localparam int K  = 128;
  localparam int N  = 32;
  localparam int AW = $clog2(N);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          task_grant = 1'b0;
  logic          task_end = 1'b0;
  logic [K-1:0]  task_res = '0;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [K-1:0]  res_data;
  logic [AW-1:0] res_idx;
  logic          res_last;
  logic          busy;
  logic          len_err;
  logic          ovf_err;
  logic          err_clr = 1'b0;

  iddmm_res_buf #(.K(K), .N(N), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .task_grant(task_grant), .task_end(task_end),
    .task_res(task_res), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_idx(res_idx), .res_last(res_last), .busy(busy),
    .len_err(len_err), .ovf_err(ovf_err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [K-1:0]  data;
    logic [AW-1:0] idx;
    logic          last;
  } exp_t;

  exp_t         exp_q[$];
  logic [K-1:0] mdl_buf [N];
  int           n_checks = 0;
  int           n_fail = 0;
  int           hs_cnt = 0;
  int           hs_base = 0;
  int           ready_mode = 0;
  bit           exp_len = 0;
  bit           exp_ovf = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [K-1:0] rand_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Consumer-side ready pattern: 0 always, 1 toggling, 2 random, 3 held low.
  initial forever begin
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       res_ready = 1'b1;
      1:       res_ready = ~res_ready;
      2:       res_ready = 1'($urandom_range(0, 1));
      default: res_ready = 1'b0;
    endcase
  end

  // Monitor: every handshake consumes one expected word; stalled words must not change.
  logic stall_p = 1'b0;
  exp_t held;
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_p = 1'b0;
    end else begin
      if (stall_p && res_valid)
        check("stall_hold", 256'({res_data, res_idx, res_last}), 256'(held));
      if (res_valid && res_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_word: got idx %0d data %0h, expected no word", res_idx, res_data);
        end else begin
          check("drain_word", 256'({res_data, res_idx, res_last}), 256'(exp_q.pop_front()));
        end
      end
      stall_p = res_valid && !res_ready;
      held    = '{data: res_data, idx: res_idx, last: res_last};
    end
  end

  // Sends one result of len words; the reference drains the whole N-entry buffer in configured order.
  task automatic send_result(input int len, input bit gaps);
    logic [K-1:0] w;
    int idx;
    hs_base = hs_cnt;
    for (int i = 0; i < len; i++) begin
      if (gaps) begin
        while ($urandom_range(0, 3) == 0) begin
          @(posedge clk); #1;
          task_grant = 1'b0;
          task_end   = 1'b0;
        end
      end
      @(posedge clk); #1;
      w = rand_word();
      task_grant = 1'b1;
      task_end   = (i == len - 1);
      task_res   = w;
      if (i < N) mdl_buf[i] = w;
      if (i == 1) check("busy_capture", 256'(busy), 256'(1));
    end
    @(posedge clk); #1;
    task_grant = 1'b0;
    task_end   = 1'b0;
    check("valid_after_end", 256'(res_valid), 256'(1));
    if (len != N) exp_len = 1;
    for (int k = 0; k < N; k++) begin
`ifdef IDDMM_RES_MSW_FIRST_EN
      idx = N - 1 - k;
`else
      idx = k;
`endif
      exp_q.push_back('{data: mdl_buf[idx], idx: AW'(idx), last: (k == N - 1)});
    end
  endtask

  task automatic wait_drain(input string name);
    int cyc = 0;
    while ((exp_q.size() != 0 || res_valid) && cyc < 3000) begin
      @(posedge clk); #2;
      cyc++;
    end
    if (cyc >= 3000) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: %0d words still pending, expected 0", name, exp_q.size());
      exp_q.delete();
    end
    check({name, "_handshakes"}, 256'(hs_cnt - hs_base), 256'(N));
    check({name, "_busy_after"}, 256'(busy), 256'(0));
    check({name, "_len_err"}, 256'(len_err), 256'(exp_len));
    check({name, "_ovf_err"}, 256'(ovf_err), 256'(exp_ovf));
  endtask

  task automatic clear_errors();
    @(posedge clk); #1;
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    exp_len = 0;
    exp_ovf = 0;
    check("err_clr_flags", 256'({len_err, ovf_err}), 256'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time exceeded, expected completion");
    $fatal(1);
  end

  initial begin
    int len;
    int cyc;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 256'({res_valid, res_data, res_idx, res_last, busy, len_err, ovf_err}), 256'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Full result, ready held high, then with ready toggling.
    ready_mode = 0;
    send_result(N, 0);
    wait_drain("full_ready");
    ready_mode = 1;
    send_result(N, 0);
    wait_drain("full_toggle");

    // Short result: stale tail entries still drain; error clears on request.
    ready_mode = 0;
    send_result(20, 0);
    wait_drain("short20");
    clear_errors();

    // Long result: extra words dropped.
    send_result(N + 8, 0);
    wait_drain("long40");
    clear_errors();

    // Grants during a stalled drain, including a same-cycle clear.
    ready_mode = 3;
    @(posedge clk); #1;
    send_result(N, 0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      task_grant = 1'b1;
      task_end   = 1'($urandom_range(0, 1));
      task_res   = rand_word();
    end
    @(posedge clk); #1;
    task_grant = 1'b1;
    err_clr    = 1'b1;
    check("ovf_set", 256'(ovf_err), 256'(1));
    @(posedge clk); #1;
    err_clr = 1'b0;
    check("clear_wins", 256'(ovf_err), 256'(0));
    @(posedge clk); #1;
    task_grant = 1'b0;
    task_end   = 1'b0;
    check("ovf_reset_again", 256'(ovf_err), 256'(1));
    check("ovf_still_valid", 256'(res_valid), 256'(1));
    exp_ovf = 1;
    ready_mode = 0;
    wait_drain("overflow");
    clear_errors();

    // Randomized lengths, gaps and consumer behaviour.
    for (int r = 0; r < 8; r++) begin
      case ($urandom_range(0, 2))
        0:       len = N;
        1:       len = $urandom_range(1, N - 1);
        default: len = $urandom_range(N + 1, N + 8);
      endcase
      ready_mode = $urandom_range(0, 2);
      send_result(len, 1);
      wait_drain("random");
      if ($urandom_range(0, 1) == 1) clear_errors();
    end

    // Reset in the middle of a drain, then a clean result.
    ready_mode = 0;
    send_result(N, 0);
    cyc = 0;
    while (hs_cnt - hs_base < 10 && cyc < 200) begin
      @(posedge clk); #2;
      cyc++;
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("mid_reset_outputs", 256'({res_valid, res_data, res_idx, res_last, busy, len_err, ovf_err}), 256'(0));
    exp_len = 0;
    exp_ovf = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    send_result(N, 0);
    wait_drain("after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
